// File: rtl/defs_div_sqrt_mvp.sv
// Shared definitions for the div/sqrt datapath: formats, rounding modes,
// flag positions and per-format constants.
package defs_div_sqrt_mvp;

    localparam int MANT_W = 56;
    localparam int EXP_W  = 13;

    localparam logic [EXP_W-1:0]      C_EXP_ONE_FP64 = 13'h03FF;
    localparam logic signed [EXP_W:0] C_EXT_ONE      = 14'sd1;

    localparam logic [2:0] C_RM_NEAREST  = 3'h0;
    localparam logic [2:0] C_RM_TRUNC    = 3'h1;
    localparam logic [2:0] C_RM_PLUSINF  = 3'h2;
    localparam logic [2:0] C_RM_MINUSINF = 3'h3;

    typedef enum logic [1:0] {
        FMT_FP32    = 2'b00,
        FMT_FP64    = 2'b01,
        FMT_FP16    = 2'b10,
        FMT_FP16ALT = 2'b11
    } fmt_e;

    localparam int FF_NV = 4;
    localparam int FF_DZ = 3;
    localparam int FF_OF = 2;
    localparam int FF_UF = 1;
    localparam int FF_NX = 0;

    localparam logic [63:0] C_QNAN_FP64    = 64'h7FF8_0000_0000_0000;
    localparam logic [31:0] C_QNAN_FP32    = 32'h7FC0_0000;
    localparam logic [15:0] C_QNAN_FP16    = 16'h7E00;
    localparam logic [15:0] C_QNAN_FP16ALT = 16'h7FC0;

    localparam logic [63:0] C_MAXF_FP64    = 64'h7FEF_FFFF_FFFF_FFFF;
    localparam logic [31:0] C_MAXF_FP32    = 32'h7F7F_FFFF;
    localparam logic [15:0] C_MAXF_FP16    = 16'h7BFF;
    localparam logic [15:0] C_MAXF_FP16ALT = 16'h7F7F;

    // Stage-1 register contents: fraction is right-aligned to the format width.
    typedef struct packed {
        logic           sign;
        logic [1:0]     fmt;
        logic [2:0]     rm;
        logic           nan;
        logic           inf;
        logic           zero;
        logic           nv;
        logic           dz;
        logic           tiny;
        logic [EXP_W:0] exp;
        logic [51:0]    frac;
        logic           round;
        logic           sticky;
    } s1_t;

    function automatic logic [5:0] frac_width(input logic [1:0] fmt);
        case (fmt)
            FMT_FP64: frac_width = 6'd52;
            FMT_FP32: frac_width = 6'd23;
            FMT_FP16: frac_width = 6'd10;
            default:  frac_width = 6'd7;
        endcase
    endfunction

    function automatic logic [EXP_W:0] exp_inf(input logic [1:0] fmt);
        case (fmt)
            FMT_FP64: exp_inf = 14'd2047;
            FMT_FP32: exp_inf = 14'd255;
            FMT_FP16: exp_inf = 14'd31;
            default:  exp_inf = 14'd255;
        endcase
    endfunction

endpackage

// File: rtl/norm_round_pack_mvp_round_pack.sv
// Combinational round/pack stage: rounding decision, carry into exponent,
// overflow saturation, special-value overrides and NaN-boxing.
module round_pack_mvp
    import defs_div_sqrt_mvp::*;
(
    input  logic           sign,
    input  logic [1:0]     fmt,
    input  logic [2:0]     rm,
    input  logic [EXP_W:0] exp,
    input  logic [51:0]    frac,
    input  logic           round,
    input  logic           sticky,
    input  logic           tiny,
    input  logic           nan,
    input  logic           inf,
    input  logic           zero,
    input  logic           nv,
    input  logic           dz,
    output logic [63:0]    result,
    output logic [4:0]     fflags
);

    logic [5:0]     fw;
    logic           inexact, up, carry, of, sat_max;
    logic [52:0]    frac_sum;
    logic [51:0]    frac_mask, frac_r;
    logic [EXP_W:0] exp_r;
    logic [63:0]    packed_v, inf_v, zero_v, max_v, qnan_v;

    always_comb begin
        fw      = frac_width(fmt);
        inexact = round | sticky;
        case (rm)
            C_RM_TRUNC:    up = 1'b0;
            C_RM_PLUSINF:  up = !sign && inexact;
            C_RM_MINUSINF: up = sign && inexact;
            default:       up = round && (sticky || frac[0]);
        endcase

        // A carry out of the fraction bumps the exponent; for a denormal this
        // lands exactly on the minimum normal.
        frac_sum  = {1'b0, frac} + 53'(up);
        frac_mask = (52'(1) << fw) - 52'(1);
        carry     = frac_sum[fw];
        frac_r    = frac_sum[51:0] & frac_mask;
        exp_r     = exp + (EXP_W+1)'(carry);
        of        = exp_r >= exp_inf(fmt);
        sat_max   = (rm == C_RM_TRUNC) || ((rm == C_RM_PLUSINF) && sign) ||
                    ((rm == C_RM_MINUSINF) && !sign);

        case (fmt)
            FMT_FP64: begin
                packed_v = {sign, exp_r[10:0], frac_r};
                inf_v    = {sign, 11'h7FF, 52'd0};
                zero_v   = {sign, 63'd0};
                max_v    = {sign, C_MAXF_FP64[62:0]};
                qnan_v   = C_QNAN_FP64;
            end
            FMT_FP32: begin
                packed_v = {32'hFFFF_FFFF, sign, exp_r[7:0], frac_r[22:0]};
                inf_v    = {32'hFFFF_FFFF, sign, 8'hFF, 23'd0};
                zero_v   = {32'hFFFF_FFFF, sign, 31'd0};
                max_v    = {32'hFFFF_FFFF, sign, C_MAXF_FP32[30:0]};
                qnan_v   = {32'hFFFF_FFFF, C_QNAN_FP32};
            end
            FMT_FP16: begin
                packed_v = {48'hFFFF_FFFF_FFFF, sign, exp_r[4:0], frac_r[9:0]};
                inf_v    = {48'hFFFF_FFFF_FFFF, sign, 5'h1F, 10'd0};
                zero_v   = {48'hFFFF_FFFF_FFFF, sign, 15'd0};
                max_v    = {48'hFFFF_FFFF_FFFF, sign, C_MAXF_FP16[14:0]};
                qnan_v   = {48'hFFFF_FFFF_FFFF, C_QNAN_FP16};
            end
            default: begin
                packed_v = {48'hFFFF_FFFF_FFFF, sign, exp_r[7:0], frac_r[6:0]};
                inf_v    = {48'hFFFF_FFFF_FFFF, sign, 8'hFF, 7'd0};
                zero_v   = {48'hFFFF_FFFF_FFFF, sign, 15'd0};
                max_v    = {48'hFFFF_FFFF_FFFF, sign, C_MAXF_FP16ALT[14:0]};
                qnan_v   = {48'hFFFF_FFFF_FFFF, C_QNAN_FP16ALT};
            end
        endcase

        result = packed_v;
        fflags = {nv, dz, 1'b0, tiny && inexact, inexact};
        if (nan) begin
            result = qnan_v;
            fflags = {nv, dz, 3'b000};
        end else if (inf) begin
            result = inf_v;
            fflags = {nv, dz, 3'b000};
        end else if (zero) begin
            result = zero_v;
            fflags = {nv, dz, 3'b000};
        end else if (of) begin
            result = sat_max ? max_v : inf_v;
            fflags = {nv, dz, 1'b1, tiny && inexact, 1'b1};
        end
    end

endmodule

// File: rtl/norm_round_pack_mvp.sv
// Output end of the div/sqrt datapath: stage 1 normalises/denormalises,
// stage 2 rounds and packs into a registered result with valid/ready.
module norm_round_pack_mvp
    import defs_div_sqrt_mvp::*;
(
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Kill_SI,
    input  logic              Valid_SI,
    output logic              Ready_SO,
    input  logic              Sign_SI,
    input  logic [EXP_W-1:0]  Exp_DI,
    input  logic [MANT_W-1:0] Mant_DI,
    input  logic [1:0]        Format_sel_SI,
    input  logic [2:0]        RM_SI,
    input  logic              NaN_SI,
    input  logic              Inf_SI,
    input  logic              Zero_SI,
    input  logic              NV_SI,
    input  logic              DZ_SI,
    output logic              Valid_SO,
    input  logic              Ready_SI,
    output logic [63:0]       Result_DO,
    output logic [4:0]        Fflags_SO
);

    s1_t                   s1_d, s1_q;
    logic                  s1_valid, s2_valid, s1_advance, accept;
    logic signed [EXP_W:0] exp_in, exp_n;
    logic [MANT_W-2:0]     mant_n, sig, mask, smask;
    logic [EXP_W:0]        sh_full, cap, exp_f;
    logic [5:0]            fw, sh, rpos;
    logic                  lost, tiny;
    logic [63:0]           rp_result;
    logic [4:0]            rp_fflags;

    assign s1_advance = s1_valid && (!s2_valid || Ready_SI);
    assign Ready_SO   = !s1_valid || s1_advance;
    assign accept     = Valid_SI && Ready_SO;
    assign Valid_SO   = s2_valid;

    always_comb begin
        exp_in = {Exp_DI[EXP_W-1], Exp_DI};
        mant_n = Mant_DI[MANT_W-2:0];
        exp_n  = exp_in;
        if (Mant_DI[MANT_W-1]) begin
            mant_n = {Mant_DI[MANT_W-1:2], Mant_DI[1] | Mant_DI[0]};
            exp_n  = exp_in + C_EXT_ONE;
        end else if (!Mant_DI[MANT_W-2]) begin
            mant_n = {Mant_DI[MANT_W-3:0], 1'b0};
            exp_n  = exp_in - C_EXT_ONE;
        end

        // Past fraction width + 2 every bit already sits in the sticky region.
        fw      = frac_width(Format_sel_SI);
        sh_full = C_EXT_ONE - exp_n;
        cap     = (EXP_W+1)'(fw) + (EXP_W+1)'(2);
        sh      = (sh_full > cap) ? cap[5:0] : sh_full[5:0];
        mask    = (55'(1) << sh) - 55'(1);
        sig     = mant_n;
        lost    = 1'b0;
        tiny    = 1'b0;
        exp_f   = exp_n;
        if (exp_n[EXP_W] || (exp_n == '0)) begin
            sig   = mant_n >> sh;
            lost  = |(mant_n & mask);
            tiny  = 1'b1;
            exp_f = '0;
        end

        rpos  = 6'd53 - fw;
        smask = (55'(1) << rpos) - 55'(1);

        s1_d.sign   = Sign_SI;
        s1_d.fmt    = Format_sel_SI;
        s1_d.rm     = RM_SI;
        s1_d.nan    = NaN_SI;
        s1_d.inf    = Inf_SI;
        s1_d.zero   = Zero_SI;
        s1_d.nv     = NV_SI;
        s1_d.dz     = DZ_SI;
        s1_d.tiny   = tiny;
        s1_d.exp    = exp_f;
        s1_d.frac   = 52'(sig[53:0] >> (6'd54 - fw));
        s1_d.round  = sig[rpos];
        s1_d.sticky = lost | (|(sig & smask));
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (Kill_SI) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)
                s1_valid <= 1'b1;
            else if (s1_advance)
                s1_valid <= 1'b0;
            if (s1_advance)
                s2_valid <= 1'b1;
            else if (Ready_SI)
                s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            s1_q      <= '0;
            Result_DO <= '0;
            Fflags_SO <= '0;
        end else begin
            if (accept)
                s1_q <= s1_d;
            if (s1_advance) begin
                Result_DO <= rp_result;
                Fflags_SO <= rp_fflags;
            end
        end
    end

    round_pack_mvp u_round_pack (
        .sign   (s1_q.sign),
        .fmt    (s1_q.fmt),
        .rm     (s1_q.rm),
        .exp    (s1_q.exp),
        .frac   (s1_q.frac),
        .round  (s1_q.round),
        .sticky (s1_q.sticky),
        .tiny   (s1_q.tiny),
        .nan    (s1_q.nan),
        .inf    (s1_q.inf),
        .zero   (s1_q.zero),
        .nv     (s1_q.nv),
        .dz     (s1_q.dz),
        .result (rp_result),
        .fflags (rp_fflags)
    );

endmodule

// File: tb/tb_norm_round_pack_mvp.sv
// Directed bench for norm_round_pack_mvp: vector table plus handshake,
// kill and async-reset sequences.
module tb_norm_round_pack_mvp;

    logic        Clk_CI, Rst_RBI, Kill_SI, Valid_SI, Ready_SO, Sign_SI;
    logic [12:0] Exp_DI;
    logic [55:0] Mant_DI;
    logic [1:0]  Format_sel_SI;
    logic [2:0]  RM_SI;
    logic        NaN_SI, Inf_SI, Zero_SI, NV_SI, DZ_SI;
    logic        Valid_SO, Ready_SI;
    logic [63:0] Result_DO;
    logic [4:0]  Fflags_SO;

    norm_round_pack_mvp dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Kill_SI(Kill_SI),
        .Valid_SI(Valid_SI), .Ready_SO(Ready_SO), .Sign_SI(Sign_SI),
        .Exp_DI(Exp_DI), .Mant_DI(Mant_DI), .Format_sel_SI(Format_sel_SI),
        .RM_SI(RM_SI), .NaN_SI(NaN_SI), .Inf_SI(Inf_SI), .Zero_SI(Zero_SI),
        .NV_SI(NV_SI), .DZ_SI(DZ_SI), .Valid_SO(Valid_SO), .Ready_SI(Ready_SI),
        .Result_DO(Result_DO), .Fflags_SO(Fflags_SO)
    );

    initial begin
        Clk_CI = 1'b0;
        forever #5 Clk_CI = ~Clk_CI;
    end

    typedef struct {
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        sign;
        logic [12:0] exp;
        logic [55:0] mant;
        logic [4:0]  ovr;   // {nan, inf, zero, nv, dz}
        logic [63:0] res;
        logic [4:0]  ff;
    } vec_t;

    localparam int NVEC = 19;
    localparam logic [55:0] B55 = 56'h80_0000_0000_0000;
    localparam logic [55:0] B54 = 56'h40_0000_0000_0000;
    localparam logic [55:0] B53 = 56'h20_0000_0000_0000;
    localparam logic [55:0] B43 = 56'h00_0800_0000_0000;

    vec_t        tv[NVEC];
    int          checks = 0;
    int          failures = 0;
    int          lat, n_acc, n_out;
    int          seq[4] = '{0, 1, 3, 8};
    logic        held_valid;
    logic [63:0] held_res;
    logic [4:0]  held_ff;

    function automatic vec_t mk(input logic [1:0] f, input logic [2:0] r, input logic s,
                                input logic [12:0] e, input logic [55:0] m, input logic [4:0] o,
                                input logic [63:0] res, input logic [4:0] ff);
        vec_t v;
        v.fmt = f; v.rm = r; v.sign = s; v.exp = e; v.mant = m; v.ovr = o;
        v.res = res; v.ff = ff;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        Format_sel_SI = v.fmt;
        RM_SI         = v.rm;
        Sign_SI       = v.sign;
        Exp_DI        = v.exp;
        Mant_DI       = v.mant;
        {NaN_SI, Inf_SI, Zero_SI, NV_SI, DZ_SI} = v.ovr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // fmt: 00 FP32, 01 FP64, 10 FP16, 11 FP16alt; rm: 0 RNE, 1 RTZ, 2 RUP, 3 RDN
        tv[0]  = mk(2'b01, 3'd0, 1'b0, 13'd1023, B54, 5'b00000, 64'h3FF0_0000_0000_0000, 5'b00000);
        tv[1]  = mk(2'b00, 3'd0, 1'b0, 13'd255, B54, 5'b00000, 64'hFFFF_FFFF_7F80_0000, 5'b00101);
        tv[2]  = mk(2'b00, 3'd1, 1'b0, 13'd255, B54, 5'b00000, 64'hFFFF_FFFF_7F7F_FFFF, 5'b00101);
        tv[3]  = mk(2'b10, 3'd0, 1'b0, 13'd15, B54 | B43, 5'b00000, 64'hFFFF_FFFF_FFFF_3C00, 5'b00001);
        tv[4]  = mk(2'b10, 3'd2, 1'b0, 13'd15, B54 | B43, 5'b00000, 64'hFFFF_FFFF_FFFF_3C01, 5'b00001);
        tv[5]  = mk(2'b00, 3'd0, 1'b0, 13'd0, B54, 5'b00000, 64'hFFFF_FFFF_0040_0000, 5'b00000);
        tv[6]  = mk(2'b00, 3'd0, 1'b0, 13'd0, B54 | 56'd1, 5'b00000, 64'hFFFF_FFFF_0040_0000, 5'b00011);
        tv[7]  = mk(2'b11, 3'd0, 1'b1, 13'd127, B54, 5'b11000, 64'hFFFF_FFFF_FFFF_7FC0, 5'b00000);
        tv[8]  = mk(2'b01, 3'd0, 1'b0, 13'd1023, B55, 5'b00000, 64'h4000_0000_0000_0000, 5'b00000);
        tv[9]  = mk(2'b00, 3'd0, 1'b0, 13'd127, B53, 5'b00000, 64'hFFFF_FFFF_3F00_0000, 5'b00000);
        tv[10] = mk(2'b00, 3'd2, 1'b1, 13'd255, B54, 5'b00000, 64'hFFFF_FFFF_FF7F_FFFF, 5'b00101);
        tv[11] = mk(2'b01, 3'd0, 1'b1, 13'd1023, B54, 5'b01001, 64'hFFF0_0000_0000_0000, 5'b01000);
        tv[12] = mk(2'b00, 3'd0, 1'b1, 13'd255, B54, 5'b00110, 64'hFFFF_FFFF_8000_0000, 5'b10000);
        tv[13] = mk(2'b10, 3'd0, 1'b0, 13'd15, 56'h40_1800_0000_0000, 5'b00000, 64'hFFFF_FFFF_FFFF_3C02, 5'b00001);
        tv[14] = mk(2'b10, 3'd0, 1'b0, 13'd15, 56'h7F_F800_0000_0000, 5'b00000, 64'hFFFF_FFFF_FFFF_4000, 5'b00001);
        tv[15] = mk(2'b00, 3'd0, 1'b0, 13'd0, 56'h7F_FFFF_8000_0000, 5'b00000, 64'hFFFF_FFFF_0080_0000, 5'b00011);
        tv[16] = mk(2'b00, 3'd3, 1'b1, 13'd127, B54 | 56'd1, 5'b00000, 64'hFFFF_FFFF_BF80_0001, 5'b00001);
        tv[17] = mk(2'b00, 3'd2, 1'b0, 13'h1F9C, B54, 5'b00000, 64'hFFFF_FFFF_0000_0001, 5'b00011);
        tv[18] = mk(2'b10, 3'd5, 1'b0, 13'd15, 56'h40_1800_0000_0000, 5'b00000, 64'hFFFF_FFFF_FFFF_3C02, 5'b00001);

        Rst_RBI = 1'b0; Kill_SI = 1'b0; Valid_SI = 1'b0; Ready_SI = 1'b1;
        drive(tv[0]);
        repeat (2) @(negedge Clk_CI);
        check("rst_valid", 64'(Valid_SO), 64'd0);
        check("rst_ready", 64'(Ready_SO), 64'd1);
        check("rst_result", Result_DO, 64'd0);
        check("rst_fflags", 64'(Fflags_SO), 64'd0);
        Rst_RBI = 1'b1;
        @(negedge Clk_CI);

        for (int i = 0; i < NVEC; i++) begin
            drive(tv[i]);
            Valid_SI = 1'b1;
            #1;
            check($sformatf("v%0d_ready", i), 64'(Ready_SO), 64'd1);
            @(negedge Clk_CI);
            Valid_SI = 1'b0;
            lat = 1;
            while (!Valid_SO && lat < 10) begin
                @(negedge Clk_CI);
                lat++;
            end
            if (i == 0) check("latency", 64'(lat), 64'd2);
            check($sformatf("v%0d_valid", i), 64'(Valid_SO), 64'd1);
            check($sformatf("v%0d_result", i), Result_DO, tv[i].res);
            check($sformatf("v%0d_fflags", i), 64'(Fflags_SO), 64'(tv[i].ff));
        end
        @(negedge Clk_CI);
        check("drain_valid", 64'(Valid_SO), 64'd0);

        // back-to-back with downstream stalled for five cycles
        Ready_SI = 1'b0; n_acc = 0; n_out = 0; held_valid = 1'b0;
        held_res = '0; held_ff = '0;
        for (int c = 0; c < 5; c++) begin
            drive(tv[seq[n_acc]]);
            Valid_SI = 1'b1;
            #1;
            if (c >= 2) check($sformatf("stall_ready_c%0d", c), 64'(Ready_SO), 64'd0);
            if (Valid_SO) begin
                if (held_valid) begin
                    check($sformatf("stall_hold_res_c%0d", c), Result_DO, held_res);
                    check($sformatf("stall_hold_ff_c%0d", c), 64'(Fflags_SO), 64'(held_ff));
                end
                held_res = Result_DO; held_ff = Fflags_SO; held_valid = 1'b1;
            end
            if (Ready_SO) n_acc++;
            @(negedge Clk_CI);
        end
        check("stall_accepted", 64'(n_acc), 64'd2);
        check("stall_valid", 64'(Valid_SO), 64'd1);
        Ready_SI = 1'b1;
        for (int c = 0; c < 30 && n_out < 4; c++) begin
            if (n_acc < 4) begin
                drive(tv[seq[n_acc]]);
                Valid_SI = 1'b1;
            end else begin
                Valid_SI = 1'b0;
            end
            #1;
            if (Valid_SO) begin
                check($sformatf("seq%0d_result", n_out), Result_DO, tv[seq[n_out]].res);
                check($sformatf("seq%0d_fflags", n_out), 64'(Fflags_SO), 64'(tv[seq[n_out]].ff));
                n_out++;
            end
            if (Ready_SO && Valid_SI) n_acc++;
            @(negedge Clk_CI);
        end
        Valid_SI = 1'b0;
        check("seq_count", 64'(n_out), 64'd4);
        @(negedge Clk_CI);
        check("seq_no_dup", 64'(Valid_SO), 64'd0);

        // kill with both stages full, then kill while an input is offered
        Ready_SI = 1'b0;
        drive(tv[9]); Valid_SI = 1'b1;
        @(negedge Clk_CI);
        drive(tv[10]);
        @(negedge Clk_CI);
        check("kill_pre_valid", 64'(Valid_SO), 64'd1);
        check("kill_pre_ready", 64'(Ready_SO), 64'd0);
        Kill_SI = 1'b1; drive(tv[13]);
        @(negedge Clk_CI);
        check("kill_valid", 64'(Valid_SO), 64'd0);
        check("kill_ready", 64'(Ready_SO), 64'd1);
        Ready_SI = 1'b1;
        @(negedge Clk_CI);
        Kill_SI = 1'b0; Valid_SI = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk_CI);
            check($sformatf("kill_drop_c%0d", c), 64'(Valid_SO), 64'd0);
        end

        // asynchronous reset in the middle of the low clock phase
        Ready_SI = 1'b0;
        drive(tv[1]); Valid_SI = 1'b1;
        @(negedge Clk_CI);
        drive(tv[2]);
        @(negedge Clk_CI);
        Valid_SI = 1'b0;
        check("arst_pre_valid", 64'(Valid_SO), 64'd1);
        check("arst_pre_result", Result_DO, tv[1].res);
        #2 Rst_RBI = 1'b0;
        #1;
        check("arst_valid", 64'(Valid_SO), 64'd0);
        check("arst_ready", 64'(Ready_SO), 64'd1);
        check("arst_result", Result_DO, 64'd0);
        check("arst_fflags", 64'(Fflags_SO), 64'd0);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1; Ready_SI = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk_CI);
            check($sformatf("arst_lost_c%0d", c), 64'(Valid_SO), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
